// File: rtl/i2s_rx_sample_capture.sv
// I2S receiver for one channel: synchronises the codec pins into clk, aligns to the
// word-select edge and presents the latest complete sample as a held parallel word.
//
// state   | meaning
// ALIGN   | waiting for the first genuine word edge into the selected channel
// DELAY   | word edge seen; the next bclk rise carries the MSB
// SHIFT   | capturing the remaining bits MSB first
// SKIP    | sample done; ignoring the rest of the slot and the other channel
module i2s_rx_sample_capture #(
  parameter int CHANNEL = 0,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aud_bclk,
  input  logic              aud_lrclk,
  input  logic              aud_dat,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic [15:0]       sample_cnt,
  output logic              frame_err
);

  localparam int                CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic              CH_SEL   = 1'(CHANNEL);

  typedef enum logic [1:0] {ST_ALIGN, ST_DELAY, ST_SHIFT, ST_SKIP} state_t;

  logic [2:0]        bclk_sync_q, bclk_sync_d;
  logic [2:0]        lr_sync_q, lr_sync_d;
  logic [2:0]        dat_sync_q, dat_sync_d;
  logic              bclk_rise_q, bclk_rise_d;
  state_t            state_q, state_d;
  logic              lr_seen_q, lr_seen_d;
  logic              lr_prev_q, lr_prev_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] sample_out_q, sample_out_d;
  logic              sample_valid_q, sample_valid_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;
  logic              frame_err_q, frame_err_d;

  logic              lr_s, dat_s, word_edge, ch_match;
  logic [DATA_W-1:0] shreg_next;

  // Third stage of lrclk/dat lines up with the registered bclk rise.
  assign lr_s       = lr_sync_q[2];
  assign dat_s      = dat_sync_q[2];
  assign word_edge  = lr_seen_q && (lr_s != lr_prev_q);
  assign ch_match   = (lr_s == CH_SEL);
  assign shreg_next = {shreg_q[DATA_W-2:0], dat_s};

  always_comb begin
    bclk_sync_d    = {bclk_sync_q[1:0], aud_bclk};
    lr_sync_d      = {lr_sync_q[1:0], aud_lrclk};
    dat_sync_d     = {dat_sync_q[1:0], aud_dat};
    bclk_rise_d    = bclk_sync_q[1] & ~bclk_sync_q[2];
    state_d        = state_q;
    lr_seen_d      = lr_seen_q;
    lr_prev_d      = lr_prev_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    sample_cnt_d   = sample_cnt_q;
    frame_err_d    = frame_err_q;

    if (bclk_rise_q) begin
      lr_seen_d = 1'b1;
      lr_prev_d = lr_s;
      unique case (state_q)
        ST_ALIGN, ST_SKIP: begin
          if (word_edge && ch_match) begin
            state_d   = ST_DELAY;
            bit_cnt_d = '0;
          end
        end
        ST_DELAY, ST_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            // A completed word wins over a coincident edge, which is then judged as from SKIP.
            sample_out_d   = shreg_next;
            sample_valid_d = 1'b1;
            sample_cnt_d   = sample_cnt_q + 16'd1;
            bit_cnt_d      = '0;
            state_d        = (word_edge && ch_match) ? ST_DELAY : ST_SKIP;
          end else if (word_edge) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = ch_match ? ST_DELAY : ST_SKIP;
          end else begin
            shreg_d   = shreg_next;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = ST_SHIFT;
          end
        end
        default: state_d = ST_ALIGN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q    <= '0;
      lr_sync_q      <= '0;
      dat_sync_q     <= '0;
      bclk_rise_q    <= 1'b0;
      state_q        <= ST_ALIGN;
      lr_seen_q      <= 1'b0;
      lr_prev_q      <= 1'b0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      sample_cnt_q   <= '0;
      frame_err_q    <= 1'b0;
    end else begin
      bclk_sync_q    <= bclk_sync_d;
      lr_sync_q      <= lr_sync_d;
      dat_sync_q     <= dat_sync_d;
      bclk_rise_q    <= bclk_rise_d;
      state_q        <= state_d;
      lr_seen_q      <= lr_seen_d;
      lr_prev_q      <= lr_prev_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      sample_cnt_q   <= sample_cnt_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign sample_cnt   = sample_cnt_q;
  assign frame_err    = frame_err_q;

endmodule
